// File: rtl/spi_slave_rx_if.sv
// Bus bundle for spi_slave_rx: SPI pins from the master plus the byte
// hand-off and status signals toward the consumer.
interface spi_slave_rx_if #(
  parameter int DATA_W = 8
);
  logic              sclk;
  logic              cs;
  logic              mosi;
  logic              rx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              frame_err;
  logic              overrun;
  logic              busy;

  modport slave (
    input  sclk, cs, mosi, rx_ready,
    output rx_data, rx_valid, frame_err, overrun, busy
  );

  modport master (
    output sclk, cs, mosi, rx_ready,
    input  rx_data, rx_valid, frame_err, overrun, busy
  );
endinterface

// File: rtl/spi_slave_rx.sv
// SPI receive-only slave, oversampled by clk: discards PRE_EDGES start pulses,
// then shifts DATA_W bits MSB first and hands the byte off with valid/ready.
//
// state   | meaning
// IDLE    | waiting for cs low
// PRE     | counting the start-phase sclk edges, mosi ignored
// SHIFT   | sampling payload bits on sclk rising edges
// WAIT_CS | byte done, ignoring sclk until cs goes high
module spi_slave_rx #(
  parameter int DATA_W    = 8,
  parameter int PRE_EDGES = 1
) (
  input  logic           clk,
  input  logic           rst,
  spi_slave_rx_if.slave  bus
);
  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam int PRE_W = (PRE_EDGES < 2) ? 1 : $clog2(PRE_EDGES);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'((PRE_EDGES > 0) ? PRE_EDGES - 1 : 0);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, PRE, SHIFT, WAIT_CS} state_t;

  logic [1:0]        sclk_sync_q, sclk_sync_d;
  logic [1:0]        cs_sync_q, cs_sync_d;
  logic [1:0]        mosi_sync_q, mosi_sync_d;
  logic              sclk_prev_q, sclk_prev_d;
  state_t            state_q, state_d;
  logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;

  logic              sclk_rise;
  logic              cs_hi;
  logic              mosi_s;
  logic              byte_done;
  logic [DATA_W-1:0] new_byte;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[0], bus.sclk};
    cs_sync_d   = {cs_sync_q[0], bus.cs};
    mosi_sync_d = {mosi_sync_q[0], bus.mosi};
    sclk_prev_d = sclk_sync_q[1];
  end

  assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
  assign cs_hi     = cs_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign new_byte  = {shift_q[DATA_W-2:0], mosi_s};

  // cs going high before the byte completes wins over a same-cycle sclk edge.
  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    byte_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!cs_hi) begin
          pre_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = (PRE_EDGES == 0) ? SHIFT : PRE;
        end
      end
      PRE: begin
        if (cs_hi) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else if (sclk_rise) begin
          if (pre_cnt_q == PRE_LAST) state_d = SHIFT;
          else                       pre_cnt_d = pre_cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (cs_hi) begin
          frame_err_d = 1'b1;
          shift_d     = '0;
          state_d     = IDLE;
        end else if (sclk_rise) begin
          shift_d   = new_byte;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
            byte_done = 1'b1;
            state_d   = WAIT_CS;
          end
        end
      end
      WAIT_CS: begin
        if (cs_hi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A byte arriving while the previous one is still pending and not taken is dropped.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
    if (byte_done) begin
      if (!rx_valid_q || bus.rx_ready) begin
        rx_data_d  = new_byte;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && bus.rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= 2'b00;
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b00;
      sclk_prev_q <= 1'b0;
      state_q     <= IDLE;
      pre_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: vector table of whole frames, hand-written corner
// sequences, then random frames against a frame-level hand-off model.
module tb_spi_slave_rx;
  logic clk = 1'b0;
  logic rst;

  spi_slave_rx_if #(.DATA_W(8)) bus ();

  spi_slave_rx #(.DATA_W(8), .PRE_EDGES(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int acc_cnt  = 0;
  logic [7:0] acc_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.frame_err) ferr_cnt++;
      if (bus.overrun) ovr_cnt++;
      if (bus.rx_valid && bus.rx_ready) begin
        acc_cnt++;
        acc_q.push_back(bus.rx_data);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse(input logic b);
    bus.sclk = 1'b0;
    bus.mosi = b;
    ticks(4);
    bus.sclk = 1'b1;
    ticks(4);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic pre_bit, input int extra);
    bus.cs = 1'b0;
    ticks(4);
    pulse(pre_bit);
    for (int i = 0; i < nbits; i++) pulse(d[7-i]);
    for (int i = 0; i < extra; i++) pulse(1'($urandom_range(1, 0)));
    bus.sclk = 1'b0;
    ticks(4);
    bus.cs = 1'b1;
    ticks(6);
  endtask

  typedef struct {
    logic [7:0] data;
    int         nbits;
    logic       pre_bit;
    int         extra;
    logic       ready;
    logic       drain;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_ferr;
    int         exp_ovr;
    int         exp_acc;
  } vec_t;

  vec_t vec[7];

  initial begin
    int f0, o0, a0, base;
    logic [7:0] d;
    logic [7:0] ed;
    logic ev, rdy, ab, pre;
    int nb, ex, ef, eo;
    logic [7:0] exp_q[$];

    vec[0] = '{8'hA5, 8, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'hA5, 0, 0, 1};
    vec[1] = '{8'h3C, 8, 1'b0, 0, 1'b0, 1'b0, 1'b1, 8'h3C, 0, 0, 0};
    vec[2] = '{8'hC3, 8, 1'b0, 0, 1'b0, 1'b0, 1'b1, 8'h3C, 0, 1, 0};
    vec[3] = '{8'hF0, 4, 1'b0, 0, 1'b0, 1'b1, 1'b1, 8'h3C, 1, 0, 0};
    vec[4] = '{8'h81, 8, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h81, 0, 0, 1};
    vec[5] = '{8'h00, 8, 1'b1, 2, 1'b0, 1'b1, 1'b1, 8'h00, 0, 0, 0};
    vec[6] = '{8'h7E, 8, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h7E, 0, 0, 1};

    bus.sclk = 1'b0;
    bus.cs = 1'b1;
    bus.mosi = 1'b0;
    bus.rx_ready = 1'b0;
    rst = 1'b1;
    ticks(3);
    check("rst rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst rx_data", 32'(bus.rx_data), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst frame_err", 32'(bus.frame_err), 32'd0);
    check("rst overrun", 32'(bus.overrun), 32'd0);
    rst = 1'b0;
    ticks(2);

    for (int k = 0; k < 7; k++) begin
      f0 = ferr_cnt;
      o0 = ovr_cnt;
      a0 = acc_cnt;
      bus.rx_ready = vec[k].ready;
      send_frame(vec[k].data, vec[k].nbits, vec[k].pre_bit, vec[k].extra);
      check($sformatf("v%0d rx_valid", k), 32'(bus.rx_valid), 32'(vec[k].exp_valid));
      check($sformatf("v%0d rx_data", k), 32'(bus.rx_data), 32'(vec[k].exp_data));
      check($sformatf("v%0d frame_err", k), 32'(ferr_cnt - f0), 32'(vec[k].exp_ferr));
      check($sformatf("v%0d overrun", k), 32'(ovr_cnt - o0), 32'(vec[k].exp_ovr));
      check($sformatf("v%0d accepted", k), 32'(acc_cnt - a0), 32'(vec[k].exp_acc));
      if (vec[k].drain) begin
        bus.rx_ready = 1'b1;
        tick();
        bus.rx_ready = 1'b0;
        tick();
        check($sformatf("v%0d drain valid", k), 32'(bus.rx_valid), 32'd0);
        check($sformatf("v%0d drain data", k), 32'(bus.rx_data), 32'(vec[k].exp_data));
      end
    end

    // early abort: busy must drop within 3 clk of cs rising
    bus.rx_ready = 1'b0;
    bus.cs = 1'b0;
    ticks(4);
    pulse(1'b0);
    for (int i = 0; i < 4; i++) pulse(1'b1);
    bus.sclk = 1'b0;
    ticks(4);
    check("abort busy before", 32'(bus.busy), 32'd1);
    f0 = ferr_cnt;
    bus.cs = 1'b1;
    ticks(3);
    check("abort busy after", 32'(bus.busy), 32'd0);
    ticks(4);
    check("abort frame_err", 32'(ferr_cnt - f0), 32'd1);
    check("abort rx_valid", 32'(bus.rx_valid), 32'd0);

    // consumer takes 0x11 in the very cycle 0x22 completes
    send_frame(8'h11, 8, 1'b0, 0);
    check("simul first valid", 32'(bus.rx_valid), 32'd1);
    o0 = ovr_cnt;
    d = 8'h22;
    bus.cs = 1'b0;
    ticks(4);
    pulse(1'b0);
    for (int i = 0; i < 7; i++) pulse(d[7-i]);
    bus.sclk = 1'b0;
    bus.mosi = d[0];
    ticks(4);
    bus.sclk = 1'b1;
    ticks(2);
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    check("simul rx_valid", 32'(bus.rx_valid), 32'd1);
    check("simul rx_data", 32'(bus.rx_data), 32'h22);
    bus.sclk = 1'b0;
    ticks(4);
    bus.cs = 1'b1;
    ticks(6);
    check("simul overrun", 32'(ovr_cnt - o0), 32'd0);
    check("simul hold data", 32'(bus.rx_data), 32'h22);
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    tick();

    // reset during the payload of 0xFF
    bus.cs = 1'b0;
    ticks(4);
    pulse(1'b0);
    for (int i = 0; i < 3; i++) pulse(1'b1);
    rst = 1'b1;
    bus.cs = 1'b1;
    bus.sclk = 1'b0;
    tick();
    rst = 1'b0;
    check("midrst rx_valid", 32'(bus.rx_valid), 32'd0);
    check("midrst rx_data", 32'(bus.rx_data), 32'd0);
    check("midrst busy", 32'(bus.busy), 32'd0);
    check("midrst frame_err", 32'(bus.frame_err), 32'd0);
    check("midrst overrun", 32'(bus.overrun), 32'd0);
    f0 = ferr_cnt;
    ticks(20);
    check("midrst later valid", 32'(bus.rx_valid), 32'd0);
    check("midrst no frame_err", 32'(ferr_cnt - f0), 32'd0);

    // random frames against the hand-off model
    base = acc_q.size();
    ev = 1'b0;
    ed = 8'h00;
    ef = ferr_cnt;
    eo = ovr_cnt;
    for (int r = 0; r < 20; r++) begin
      d   = 8'($urandom);
      rdy = 1'($urandom_range(1, 0));
      ab  = ($urandom_range(4, 0) == 0);
      nb  = ab ? $urandom_range(7, 1) : 8;
      pre = 1'($urandom_range(1, 0));
      ex  = ab ? 0 : $urandom_range(2, 0);
      bus.rx_ready = rdy;
      send_frame(d, nb, pre, ex);
      if (rdy && ev) begin
        exp_q.push_back(ed);
        ev = 1'b0;
      end
      if (ab) begin
        ef++;
      end else if (!ev) begin
        ed = d;
        ev = 1'b1;
        if (rdy) begin
          exp_q.push_back(d);
          ev = 1'b0;
        end
      end else begin
        eo++;
      end
      check($sformatf("rnd%0d rx_valid", r), 32'(bus.rx_valid), 32'(ev));
      check($sformatf("rnd%0d rx_data", r), 32'(bus.rx_data), 32'(ed));
      check($sformatf("rnd%0d frame_err", r), 32'(ferr_cnt), 32'(ef));
      check($sformatf("rnd%0d overrun", r), 32'(ovr_cnt), 32'(eo));
      check($sformatf("rnd%0d busy", r), 32'(bus.busy), 32'd0);
    end
    check("rnd accepted count", 32'(acc_q.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < acc_q.size())
        check($sformatf("rnd accepted[%0d]", i), 32'(acc_q[base+i]), 32'(exp_q[i]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
